// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^4)/GF((2^4)^2) arithmetic, S-box maps and FSM type
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } sb_state_e;

  localparam logic [7:0] AFFINE_C = 8'h63;
  // GF(2^4) reduction x^4+x+1 (low four bits) and the composite-field constant v
  // of x^2+x+v; v=x^3+x^2 has trace 1, so the quadratic is irreducible.
  localparam logic [3:0] GF4_POLY = 4'h3;
  localparam logic [3:0] GF4_V    = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ GF4_POLY) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf4_sq_v(input logic [3:0] a);
    return gf4_mul(gf4_sq(a), GF4_V);
  endfunction

  // a^14 = a^2 * a^4 * a^8; maps 0 to 0 as the S-box requires.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // Composite-field product of (h*x + l) elements, used only to derive the maps.
  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(hh, GF4_V) ^ gf4_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // Evaluates the AES field polynomial x^8+x^4+x^3+x+1 at a composite element.
  function automatic logic [7:0] aes_poly_at(input logic [7:0] b);
    logic [7:0] p2;
    logic [7:0] p3;
    logic [7:0] p4;
    logic [7:0] p8;
    p2 = gf8c_mul(b, b);
    p3 = gf8c_mul(p2, b);
    p4 = gf8c_mul(p2, p2);
    p8 = gf8c_mul(p4, p4);
    return p8 ^ p4 ^ p3 ^ b ^ 8'h01;
  endfunction

  function automatic logic [7:0] find_root();
    logic [7:0] root;
    root = '0;
    for (int c = 255; c >= 2; c--) begin
      if (aes_poly_at(8'(c)) == 8'h00) root = 8'(c);
    end
    return root;
  endfunction

  // Column i is the image of x^i: the polynomial basis maps onto powers of a root.
  function automatic logic [63:0] build_iso_map();
    logic [63:0] m;
    logic [7:0]  beta;
    logic [7:0]  pw;
    m    = '0;
    beta = find_root();
    pw   = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = gf8c_mul(pw, beta);
    end
    return m;
  endfunction

  function automatic logic [7:0] map_apply(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) y = y ^ m[8*i +: 8];
    end
    return y;
  endfunction

  function automatic logic [63:0] build_inv_map(input logic [63:0] m);
    logic [63:0] inv;
    logic [7:0]  unit;
    inv = '0;
    for (int j = 0; j < 8; j++) begin
      unit = 8'h01 << j;
      for (int c = 0; c < 256; c++) begin
        if (map_apply(m, 8'(c)) == unit) inv[8*j +: 8] = 8'(c);
      end
    end
    return inv;
  endfunction

  localparam logic [63:0] ISO_MAP     = build_iso_map();
  localparam logic [63:0] ISO_INV_MAP = build_inv_map(ISO_MAP);

  function automatic logic [7:0] iso_map(input logic [7:0] x);
    return map_apply(ISO_MAP, x);
  endfunction

  function automatic logic [7:0] iso_inv_map(input logic [7:0] x);
    return map_apply(ISO_INV_MAP, x);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] y);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ AFFINE_C[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sub_bytes_seq_if.sv
// rtl/sub_bytes_seq_if.sv - input/output handshake bundle of the SubBytes engine
interface sub_bytes_seq_if;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward S-box via composite-field inversion
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] raw,
  output logic [7:0] sub
);
  logic [7:0] iso_v;
  logic [7:0] inv_v;
  logic [3:0] hi;
  logic [3:0] lo;
  logic [3:0] delta;
  logic [3:0] delta_inv;

  // (h*x+l)^-1 = h*d*x + (h+l)*d with d = (v*h^2 + h*l + l^2)^-1
  always_comb begin
    iso_v     = iso_map(raw);
    hi        = iso_v[7:4];
    lo        = iso_v[3:0];
    delta     = gf4_sq_v(hi) ^ gf4_mul(hi, lo) ^ gf4_sq(lo);
    delta_inv = gf4_inv(delta);
    inv_v     = {gf4_mul(hi, delta_inv), gf4_mul(hi ^ lo, delta_inv)};
    sub       = affine(iso_inv_map(inv_v));
  end
endmodule

// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - time-multiplexed AES SubBytes engine with valid/ready handshakes
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  sub_bytes_seq_if.slave bus
);
  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  sb_state_e     state;
  logic [CW-1:0] cnt;
  logic [127:0]  src_reg;
  logic [127:0]  res_reg;
  logic          out_valid_q;
  logic          busy_q;
  logic          ready;
  logic [7:0]    lane_raw [LANES];
  logic [7:0]    lane_sub [LANES];

  // A new block may enter when idle, or when the finished one leaves this very cycle.
  always_comb begin
    ready = !rst && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_reg;
  assign bus.busy      = busy_q;

  // Lane j works on byte cnt*LANES+j of the captured state.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_raw[j] = src_reg[8*(int'(cnt)*LANES + j) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .raw (lane_raw[g]),
      .sub (lane_sub[g])
    );
  end

  // Control FSM: capture, substitute LANES bytes per beat, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      src_reg     <= '0;
      res_reg     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            src_reg <= bus.in_data;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            res_reg[8*(int'(cnt)*LANES + j) +: 8] <= lane_sub[j];
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              src_reg <= bus.in_data;
              cnt     <= '0;
              busy_q  <= 1'b1;
              state   <= S_BUSY;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Forward AES SubBytes engine for the encryption datapath: the encrypt-side counterpart of the decrypt-side inverse S-box stage. It accepts a 128-bit state over a valid/ready handshake and substitutes all 16 bytes with the FIPS-197 forward S-box, using LANES time-multiplexed composite-field S-box instances. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the iterative encryption round.

## Interface

- LANES, default 4: number of S-box instances. Legal values are 1, 2, 4, 8, 16. BEATS = 16/LANES cycles are needed per block.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  128  state to substitute. Byte k is in_data[8k+7:8k], k=0..15.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a state this cycle.
- out_data  out  128  substituted state, same byte order as in_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high while substitution is in progress (BUSY state).

## Operation

- Per-byte function: S(x) = A(x⁻¹) ⊕ 0x63.
  - x⁻¹ is the GF(2⁸) inverse modulo x⁸+x⁴+x³+x+1, with 0⁻¹ = 0.
  - A is the FIPS-197 affine matrix.
  - The inverse is computed in the composite field GF((2⁴)²): isomorphism map, GF(2⁴) multiply/square/scale-by-v/inverse, inverse isomorphism, then the affine transform. No 256-entry table.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into src_reg, clear beat counter cnt, go to BUSY.
- BUSY:
  - Lane j (j=0..LANES-1) substitutes byte cnt·LANES+j of src_reg and writes it to the same byte position of res_reg.
  - cnt increments each cycle.
  - When cnt==BEATS-1, the write completes and the FSM goes to DONE.
- DONE:
  - out_valid=1 and out_data=res_reg, held stable until out_ready.
  - On out_ready with in_valid low: go to IDLE.
  - On out_ready with in_valid high (in_ready is 1 that cycle): capture the new state and go directly to BUSY. This gives back-to-back throughput of one block per BEATS+1 cycles.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is a combinational output. It is 0 while rst is high.
- in_valid is ignored in BUSY. The upstream stage must hold its data until in_ready.
- cnt is log2(BEATS) bits wide (1 bit minimum). For LANES=16 the FSM spends exactly one cycle in BUSY.
- Bytes not yet processed in res_reg are don't-care internally. out_data is only meaningful while out_valid=1.

## Timing

- Reset values: state=IDLE, cnt=0, out_valid=0, busy=0, in_ready=0 while rst is high, out_data=128'h0 (res_reg cleared).
- Latency: a state accepted at rising edge E₀ produces out_valid=1 in the cycle following edge E_BEATS. With LANES=4 that is 4 cycles after acceptance; with LANES=16 it is 1 cycle.
- Each S-box instance is purely combinational between src_reg and res_reg, with a single-cycle path. There is no internal S-box pipelining.
- Reset asserted mid-BUSY or mid-DONE discards the block. The next cycle is IDLE with out_valid=0. No partial result is ever presented.
- out_valid never drops without an out_ready handshake, except on rst.

## Structure

- Package aes_pkg holds:
  - GF(2⁴) functions: multiply, square, square-times-v, inverse.
  - The isomorphism and inverse-isomorphism bit maps.
  - The affine constant 8'h63.
  - The state-FSM enum typedef.
  - The decrypt-side inverse S-box reuses the same GF(2⁴) functions.
- Sub-module aes_sbox: one combinational byte in, byte out forward S-box, instantiated LANES times via generate.
- sub_bytes_seq contains only the FSM, the counter, src_reg/res_reg, and the lane byte-select muxes.

## Test plan

- Single-byte values, LANES=4, in_data={16{8'h00}}: out_data={16{8'h63}} with out_valid 4 cycles after acceptance. Likewise 8'h01→8'h7C, 8'h53→8'hED, 8'hFF→8'h16.
- FIPS-197 Appendix B round-1 state, bytes k=0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08: expect d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30. Run for each LANES ∈ {1,2,4,8,16}; the latency must equal BEATS.
- Exhaustive: 16 blocks covering bytes 0x00–0xFF. Pass each result through the inverse S-box stage and require the original bytes back.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_data must stay stable, in_ready=0, and a new in_valid is not accepted. Then raise out_ready and in_valid together: the new block is captured that cycle and busy=1 the next cycle.
- Reset: assert rst for one cycle during BUSY (cnt=2, LANES=4). Next cycle: IDLE, out_valid=0, out_data=0. A subsequent block produces a correct result.
- Random stall stress: random in_valid/out_ready over 1000 blocks versus a reference model. No lost, duplicated, or reordered blocks.
